// File: rtl/dram_arbiter.sv
// Two-core DRAM arbiter: grants one core per access, alternating on contention,
// and sequences a single DRAM write or read (with RD_LAT-cycle read latency).
module dram_arbiter #(
  parameter int unsigned RD_LAT = 1
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic [3:0] Mem_Ctrl0,
  input  logic [3:0] Mem_Ctrl1,
  input  logic [7:0] DAddress0,
  input  logic [7:0] DAddress1,
  input  logic [7:0] Ddout0,
  input  logic [7:0] Ddout1,
  output logic [7:0] Ddin0,
  output logic [7:0] Ddin1,
  output logic       dacq0,
  output logic       dacq1,
  output logic [7:0] DAddress,
  output logic [7:0] Ddout,
  output logic       wren,
  input  logic [7:0] Dq,
  output logic [2:0] dramacq
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT_RD, DONE} state_t;

  localparam logic [1:0] CNT_LAST = 2'(RD_LAT - 1);

  state_t     state_q, state_d;
  logic       owner_q, owner_d;   // 0 = core0, 1 = core1
  logic       last_q,  last_d;    // last core served
  logic       wr_q,    wr_d;
  logic [1:0] cnt_q,   cnt_d;
  logic [7:0] addr_q,  addr_d;
  logic [7:0] data_q,  data_d;
  logic [7:0] din0_q,  din0_d;
  logic [7:0] din1_q,  din1_d;

  logic req0, req1;
  logic unused_ctrl;

  assign req0        = |Mem_Ctrl0[1:0];
  assign req1        = |Mem_Ctrl1[1:0];
  assign unused_ctrl = ^{Mem_Ctrl0[3:2], Mem_Ctrl1[3:2]};

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    din0_d  = din0_q;
    din1_d  = din1_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // On contention the core not served last wins.
          owner_d = (req0 && req1) ? ~last_q : req1;
          addr_d  = owner_d ? DAddress1 : DAddress0;
          data_d  = owner_d ? Ddout1    : Ddout0;
          wr_d    = owner_d ? Mem_Ctrl1[1] : Mem_Ctrl0[1];
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        cnt_d   = '0;
        state_d = wr_q ? DONE : WAIT_RD;
      end
      WAIT_RD: begin
        if (cnt_q == CNT_LAST) begin
          if (owner_q) din1_d = Dq;
          else         din0_d = Dq;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      DONE: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      din0_q  <= '0;
      din1_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      din0_q  <= din0_d;
      din1_q  <= din1_d;
    end
  end

  always_comb begin
    wren     = (state_q == ACCESS) && wr_q;
    dacq0    = (state_q == DONE) && !owner_q;
    dacq1    = (state_q == DONE) &&  owner_q;
    dramacq  = '0;
    if (state_q != IDLE) begin
      dramacq[2] = 1'b1;
      dramacq[0] = !owner_q;
      dramacq[1] = owner_q;
    end
    DAddress = addr_q;
    Ddout    = data_q;
    Ddin0    = din0_q;
    Ddin1    = din1_q;
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter: one instance at RD_LAT=1, one at RD_LAT=3,
// each backed by a small DRAM model with a RD_LAT-deep read pipeline.
module tb_dram_arbiter;

  logic CLK = 1'b0;
  logic rst_n = 1'b1;
  always #5 CLK = ~CLK;

  // RD_LAT = 1 instance
  logic [3:0] m0, m1;
  logic [7:0] a0, a1, d0, d1;
  logic [7:0] din0_1, din1_1, daddr_1, dout_1, dq_1;
  logic       dacq0_1, dacq1_1, wren_1;
  logic [2:0] acq_1;

  // RD_LAT = 3 instance (core1 idle)
  logic [3:0] m0_3, m1_3;
  logic [7:0] a0_3, a1_3, d0_3, d1_3;
  logic [7:0] din0_3, din1_3, daddr_3, dout_3, dq_3;
  logic       dacq0_3, dacq1_3, wren_3;
  logic [2:0] acq_3;

  logic [7:0] mem1 [256];
  logic [7:0] mem3 [256];
  logic [7:0] p1_3, p2_3;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  dram_arbiter #(.RD_LAT(1)) dut1 (
    .CLK(CLK), .rst_n(rst_n),
    .Mem_Ctrl0(m0), .Mem_Ctrl1(m1),
    .DAddress0(a0), .DAddress1(a1),
    .Ddout0(d0), .Ddout1(d1),
    .Ddin0(din0_1), .Ddin1(din1_1),
    .dacq0(dacq0_1), .dacq1(dacq1_1),
    .DAddress(daddr_1), .Ddout(dout_1), .wren(wren_1),
    .Dq(dq_1), .dramacq(acq_1)
  );

  dram_arbiter #(.RD_LAT(3)) dut3 (
    .CLK(CLK), .rst_n(rst_n),
    .Mem_Ctrl0(m0_3), .Mem_Ctrl1(m1_3),
    .DAddress0(a0_3), .DAddress1(a1_3),
    .Ddout0(d0_3), .Ddout1(d1_3),
    .Ddin0(din0_3), .Ddin1(din1_3),
    .dacq0(dacq0_3), .dacq1(dacq1_3),
    .DAddress(daddr_3), .Ddout(dout_3), .wren(wren_3),
    .Dq(dq_3), .dramacq(acq_3)
  );

  always @(posedge CLK) begin
    if (wren_1) mem1[daddr_1] <= dout_1;
    dq_1 <= mem1[daddr_1];
    if (wren_3) mem3[daddr_3] <= dout_3;
    p1_3 <= mem3[daddr_3];
    p2_3 <= p1_3;
    dq_3 <= p2_3;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge CLK);
    chk("dacq_exclusive", {31'd0, dacq0_1 & dacq1_1}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem1[i] = 8'h00;
      mem3[i] = 8'h00;
    end
    mem3[8'h40] = 8'h3C;
    m0 = '0; m1 = '0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    m0_3 = '0; m1_3 = '0; a0_3 = '0; a1_3 = '0; d0_3 = '0; d1_3 = '0;

    // Reset
    #2 rst_n = 1'b0;
    step(); step();
    chk("rst_dramacq", acq_1, 3'b000);
    chk("rst_wren", wren_1, 1'b0);
    chk("rst_dacq", {dacq1_1, dacq0_1}, 2'b00);
    chk("rst_daddr", daddr_1, 8'h00);
    chk("rst_ddout", dout_1, 8'h00);
    chk("rst_ddin", {din1_1, din0_1}, 16'h0000);
    chk("rst3_dramacq", acq_3, 3'b000);

    // Core0 write, requested in the same cycle reset is released
    rst_n = 1'b1;
    m0 = 4'b0010; a0 = 8'h10; d0 = 8'hA5;
    step();
    chk("wr_wren", wren_1, 1'b1);
    chk("wr_daddr", daddr_1, 8'h10);
    chk("wr_ddout", dout_1, 8'hA5);
    chk("wr_acq_access", acq_1, 3'b101);
    m0 = '0; a0 = 8'h77; d0 = 8'h11;
    step();
    chk("wr_dacq0", dacq0_1, 1'b1);
    chk("wr_dacq1", dacq1_1, 1'b0);
    chk("wr_wren_done", wren_1, 1'b0);
    chk("wr_acq_done", acq_1, 3'b101);
    step();
    chk("wr_dacq0_end", dacq0_1, 1'b0);
    chk("wr_acq_idle", acq_1, 3'b000);
    chk("wr_daddr_hold", daddr_1, 8'h10);
    chk("wr_mem", mem1[8'h10], 8'hA5);

    // Core1 read of 0x10; address changes mid-access must not matter
    m1 = 4'b0001; a1 = 8'h10;
    step();
    chk("rd_wren", wren_1, 1'b0);
    chk("rd_daddr", daddr_1, 8'h10);
    chk("rd_acq_access", acq_1, 3'b110);
    m1 = '0; a1 = 8'h55;
    step();
    chk("rd_dacq1_wait", dacq1_1, 1'b0);
    chk("rd_acq_wait", acq_1, 3'b110);
    step();
    chk("rd_dacq1", dacq1_1, 1'b1);
    chk("rd_ddin1", din1_1, 8'hA5);
    chk("rd_ddin0_keep", din0_1, 8'h00);
    step();
    chk("rd_acq_idle", acq_1, 3'b000);

    // Core0 with both op bits set is a write only
    m0 = 4'b0011; a0 = 8'h20; d0 = 8'h5A;
    step();
    chk("rw_wren", wren_1, 1'b1);
    m0 = '0;
    step();
    chk("rw_wren_off", wren_1, 1'b0);
    chk("rw_dacq0", dacq0_1, 1'b1);
    chk("rw_ddin0_keep", din0_1, 8'h00);
    step();

    // Core0 reads back 0x20; core1's read data must survive
    m0 = 4'b0001; a0 = 8'h20;
    step();
    m0 = '0;
    step(); step();
    chk("rb_dacq0", dacq0_1, 1'b1);
    chk("rb_ddin0", din0_1, 8'h5A);
    chk("rb_ddin1_keep", din1_1, 8'hA5);
    step();

    // Reset asserted during WAIT_RD of a core0 read
    m0 = 4'b0001; a0 = 8'h10;
    step();
    m0 = '0;
    step();
    chk("ab_acq_wait", acq_1, 3'b101);
    rst_n = 1'b0;
    #1;
    chk("ab_acq", acq_1, 3'b000);
    chk("ab_outs", {wren_1, dacq1_1, dacq0_1}, 3'b000);
    chk("ab_daddr_ddout", {daddr_1, dout_1}, 16'h0000);
    chk("ab_ddin", {din1_1, din0_1}, 16'h0000);
    step();
    rst_n = 1'b1;
    step();
    chk("ab_no_dacq0", dacq0_1, 1'b0);
    chk("ab_idle", acq_1, 3'b000);

    // Both cores read continuously: core0 wins first, then alternate
    m0 = 4'b0001; a0 = 8'h10;
    m1 = 4'b0001; a1 = 8'h20;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("alt%0d_acq", k), acq_1, (k % 2 == 0) ? 3'b101 : 3'b110);
      step();
      step();
      chk($sformatf("alt%0d_dacq", k), {dacq1_1, dacq0_1}, (k % 2 == 0) ? 2'b01 : 2'b10);
      chk($sformatf("alt%0d_ddin0", k), din0_1, 8'hA5);
      chk($sformatf("alt%0d_ddin1", k), din1_1, (k == 0) ? 8'h00 : 8'h5A);
      if (k == 3) begin
        m0 = '0; m1 = '0;
      end
      step();
      chk($sformatf("alt%0d_idle", k), acq_1, 3'b000);
    end
    step();
    chk("alt_end_idle", acq_1, 3'b000);

    // RD_LAT = 3 instance: core0 read of preloaded 0x40
    m0_3 = 4'b0001; a0_3 = 8'h40;
    step();
    chk("l3_acq_access", acq_3, 3'b101);
    m0_3 = '0;
    for (int w = 0; w < 3; w++) begin
      step();
      chk($sformatf("l3_wait%0d", w), {acq_3, dacq0_3}, {3'b101, 1'b0});
    end
    step();
    chk("l3_dacq0", dacq0_3, 1'b1);
    chk("l3_ddin0", din0_3, 8'h3C);
    step();
    chk("l3_idle", {acq_3, dacq0_3}, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dram_arbiter.md
DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 Parameter RD_LAT, default 1, SHALL set the DRAM read latency in clock cycles; legal range 1..3.
REQ-002 CLK  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Mem_Ctrl0, Mem_Ctrl1  input  4 each  core request; bit0 = read, bit1 = write, bits3:2 ignored.
REQ-005 DAddress0, DAddress1  input  8 each  core data address.
REQ-006 Ddout0, Ddout1  input  8 each  core write data.
REQ-007 Ddin0, Ddin1  output  8 each  read data returned to each core.
REQ-008 dacq0, dacq1  output  1 each  access-complete pulse to each core.
REQ-009 DAddress  output  8  DRAM address.
REQ-010 Ddout  output  8  DRAM write data.
REQ-011 wren  output  1  DRAM write enable.
REQ-012 Dq  input  8  DRAM read data, valid RD_LAT cycles after the address is sampled.
REQ-013 dramacq  output  3  status: bit0 = core0 owns DRAM, bit1 = core1 owns DRAM, bit2 = arbiter not IDLE.

Function
REQ-014 A core SHALL be treated as requesting when Mem_Ctrl bit0 or bit1 is 1; if both bits are 1, the access SHALL be a write only.
REQ-015 FSM states SHALL be IDLE, ACCESS, WAIT_RD, DONE.
REQ-016 IDLE: with no request, stay in IDLE; otherwise, at the edge, grant one core, latch its address, data and op, and go to ACCESS.
REQ-017 Arbitration: a single requester SHALL be granted; if both request, the core not served last SHALL win; the last-served pointer SHALL reset to core1, so core0 wins first.
REQ-018 ACCESS (exactly 1 cycle): DAddress = latched address; Ddout = latched data; wren = 1 only for a write. Next state: DONE for a write, WAIT_RD for a read.
REQ-019 WAIT_RD SHALL last RD_LAT cycles, counted by an internal counter; on its final edge, Dq SHALL be captured into Ddin of the granted core only; then go to DONE.
REQ-020 DONE (exactly 1 cycle): dacq of the granted core = 1, the other dacq = 0; update the last-served pointer; return to IDLE.
REQ-021 Latency, measured from the IDLE sampling edge: a write SHALL have wren high in cycle +1 and dacq in cycle +2; a read SHALL have dacq in cycle +2+RD_LAT, with Ddin already valid in that cycle.
REQ-022 wren SHALL be 1 only in ACCESS for a write; dacq0 and dacq1 SHALL never both be 1.
REQ-023 DAddress and Ddout SHALL hold their last values outside ACCESS.
REQ-024 Ddin0 and Ddin1 SHALL hold the last data read for that core until that core's next read completes; writes SHALL NOT change them.
REQ-025 Requests SHALL be sampled only in IDLE; changes to inputs while a grant is in progress SHALL NOT affect the current access.
REQ-026 A core that still requests in the cycle after its dacq SHALL be treated as a new request and arbitrated normally.
REQ-027 dramacq SHALL reflect the current state: bit2 = 1 in ACCESS, WAIT_RD and DONE; bit0 or bit1 = 1 for the owner in those states; dramacq = 000 in IDLE.

Reset
REQ-028 While rst_n = 0, asynchronously: state = IDLE, wren = 0, dacq0 = dacq1 = 0, DAddress = Ddout = Ddin0 = Ddin1 = 0, dramacq = 000, last-served pointer = core1, WAIT_RD counter = 0.
REQ-029 Reset asserted mid-access SHALL abort the access immediately; no dacq pulse SHALL follow, and Ddin SHALL NOT capture Dq.
REQ-030 After rst_n rises, the first request SHALL be sampled at the first rising edge at which rst_n = 1.

Verification
REQ-031 Core0 write, Mem_Ctrl0 = 0010, DAddress0 = 0x10, Ddout0 = 0xA5 -> cycle +1: wren = 1, DAddress = 0x10, Ddout = 0xA5; cycle +2: dacq0 = 1; DRAM[0x10] = 0xA5.
REQ-032 Core1 read of 0x10 after REQ-031, RD_LAT = 1 -> dacq1 = 1 at cycle +3 with Ddin1 = 0xA5; Ddin0 unchanged.
REQ-033 Both cores request continuously from reset, both reads -> grants alternate core0, core1, core0, core1; dramacq bit0 and bit1 alternate; no overlapping dacq.
REQ-034 Mem_Ctrl0 = 0011 -> treated as write: wren pulses once; Ddin0 unchanged.
REQ-035 rst_n driven low during WAIT_RD of a core0 read -> all outputs 0 immediately; no dacq0 after rst_n rises; the next request is served normally.
REQ-036 RD_LAT = 3, core0 read -> WAIT_RD lasts 3 cycles; dacq0 at cycle +5 with correct data.
